// File: rtl/fight_pkg.sv
// Shared types, winner encodings and helpers for the hit/health and round control logic.
package fight_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIGHT,
    KO_HP,
    KO_NPC,
    DRAW
  } fight_state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_HP   = 2'b01;
  localparam logic [1:0] W_NPC  = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  localparam int HEALTH_W = 7;
  localparam int POS_W    = 10;

  // Both operands are unsigned screen positions; widen by one bit so the difference keeps its sign.
  function automatic logic [POS_W:0] abs_diff10(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    logic signed [POS_W:0] d;
    logic        [POS_W:0] r;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    r = d[POS_W] ? -d : d;
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the frame strobe into the Clk domain and turns its rising edge into a one-Clk tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= frame_clk;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign tick = sync_p1 & ~prev_p2;

endmodule

// File: rtl/hit_health_ctrl.sv
// Projectile hit detection, fighter health with invulnerability windows, and the round FSM.
// Optional HIT_FLASH_EN adds a free-running frame counter that blinks the invulnerable fighter.
module hit_health_ctrl
  import fight_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = 100,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned HIT_RANGE     = 40,
  parameter int unsigned INVULN_FRAMES = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                start,
  input  logic [POS_W-1:0]    HP_X_Pos,
  input  logic [POS_W-1:0]    NPC_X_Pos,
  input  logic [POS_W-1:0]    HP_X,
  input  logic [POS_W-1:0]    NPC_X,
  input  logic                is_HPBeat,
  input  logic                is_NPCBeat,
  output logic [HEALTH_W-1:0] HP_health,
  output logic [HEALTH_W-1:0] NPC_health,
  output logic                HP_hit,
  output logic                NPC_hit,
  output logic                HP_invuln,
  output logic                NPC_invuln,
  output logic                HP_flash,
  output logic                NPC_flash,
  output logic                game_over,
  output logic [1:0]          winner
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [HEALTH_W-1:0] FULL_HEALTH = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
  localparam logic [POS_W:0]      RANGE       = (POS_W + 1)'(HIT_RANGE);
  localparam logic [INV_W-1:0]    INV_LOAD    = INV_W'(INVULN_FRAMES);

  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h);
    if (h < DMG) return '0;
    return h - DMG;
  endfunction

  // Reset asserts asynchronously but releases two Clk edges later.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  logic tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (rst_sync),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  fight_state_t        state_q, state_d;
  logic [HEALTH_W-1:0] hp_health_q, hp_health_d;
  logic [HEALTH_W-1:0] npc_health_q, npc_health_d;
  logic [INV_W-1:0]    hp_cnt_q, hp_cnt_d;
  logic [INV_W-1:0]    npc_cnt_q, npc_cnt_d;
  logic                hp_hit_q, hp_hit_d;
  logic                npc_hit_q, npc_hit_d;
  logic [1:0]          winner_q, winner_d;
  logic                start_q;
  logic                start_rise;
  logic                hp_hit_c;
  logic                npc_hit_c;

  assign start_rise = start & ~start_q;

  always_ff @(posedge Clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q      <= IDLE;
      hp_health_q  <= FULL_HEALTH;
      npc_health_q <= FULL_HEALTH;
      hp_cnt_q     <= '0;
      npc_cnt_q    <= '0;
      hp_hit_q     <= 1'b0;
      npc_hit_q    <= 1'b0;
      winner_q     <= W_NONE;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_health_q  <= hp_health_d;
      npc_health_q <= npc_health_d;
      hp_cnt_q     <= hp_cnt_d;
      npc_cnt_q    <= npc_cnt_d;
      hp_hit_q     <= hp_hit_d;
      npc_hit_q    <= npc_hit_d;
      winner_q     <= winner_d;
      start_q      <= start;
    end
  end

  always_comb begin
    state_d      = state_q;
    hp_health_d  = hp_health_q;
    npc_health_d = npc_health_q;
    hp_cnt_d     = hp_cnt_q;
    npc_cnt_d    = npc_cnt_q;
    hp_hit_d     = 1'b0;
    npc_hit_d    = 1'b0;
    winner_d     = winner_q;

    // A counter still nonzero before this tick blocks the hit, even if it reaches zero now.
    hp_hit_c  = is_NPCBeat && (abs_diff10(NPC_X, HP_X_Pos) <= RANGE) && (hp_cnt_q == '0);
    npc_hit_c = is_HPBeat && (abs_diff10(HP_X, NPC_X_Pos) <= RANGE) && (npc_cnt_q == '0);

    if (tick) begin
      if (hp_cnt_q != '0)  hp_cnt_d  = hp_cnt_q - INV_W'(1);
      if (npc_cnt_q != '0) npc_cnt_d = npc_cnt_q - INV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FIGHT;
          hp_health_d  = FULL_HEALTH;
          npc_health_d = FULL_HEALTH;
          hp_cnt_d     = '0;
          npc_cnt_d    = '0;
          winner_d     = W_NONE;
        end
      end
      FIGHT: begin
        if (tick) begin
          if (hp_hit_c) begin
            hp_health_d = sat_sub(hp_health_q);
            hp_cnt_d    = INV_LOAD;
            hp_hit_d    = 1'b1;
          end
          if (npc_hit_c) begin
            npc_health_d = sat_sub(npc_health_q);
            npc_cnt_d    = INV_LOAD;
            npc_hit_d    = 1'b1;
          end
          if ((hp_health_d == '0) && (npc_health_d == '0)) begin
            state_d  = DRAW;
            winner_d = W_DRAW;
          end else if (hp_health_d == '0) begin
            state_d  = KO_HP;
            winner_d = W_NPC;
          end else if (npc_health_d == '0) begin
            state_d  = KO_NPC;
            winner_d = W_HP;
          end
        end
      end
      KO_HP, KO_NPC, DRAW: begin
        // Only a fresh press restarts; a key held through the KO does nothing.
        if (start_rise) begin
          state_d      = FIGHT;
          hp_health_d  = FULL_HEALTH;
          npc_health_d = FULL_HEALTH;
          hp_cnt_d     = '0;
          npc_cnt_d    = '0;
          winner_d     = W_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign HP_health  = hp_health_q;
  assign NPC_health = npc_health_q;
  assign HP_hit     = hp_hit_q;
  assign NPC_hit    = npc_hit_q;
  assign HP_invuln  = (hp_cnt_q != '0);
  assign NPC_invuln = (npc_cnt_q != '0);
  assign winner     = winner_q;
  assign game_over  = (state_q == KO_HP) || (state_q == KO_NPC) || (state_q == DRAW);

`ifdef HIT_FLASH_EN
  logic [2:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge rst_sync) begin
    if (!rst_sync) begin
      frame_cnt_q <= 3'd0;
    end else if (tick) begin
      frame_cnt_q <= frame_cnt_q + 3'd1;
    end
  end

  assign HP_flash  = HP_invuln & frame_cnt_q[2];
  assign NPC_flash = NPC_invuln & frame_cnt_q[2];
`else
  assign HP_flash  = 1'b0;
  assign NPC_flash = 1'b0;
`endif

endmodule

// File: tb/tb_hit_health_ctrl.sv
// Scoreboard bench for hit_health_ctrl, built with DAMAGE=15 so that 10 -> 0 exercises saturation.
module tb_hit_health_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       start;
  logic [9:0] HP_X_Pos, NPC_X_Pos, HP_X, NPC_X;
  logic       is_HPBeat, is_NPCBeat;
  logic [6:0] HP_health, NPC_health;
  logic       HP_hit, NPC_hit, HP_invuln, NPC_invuln, HP_flash, NPC_flash;
  logic       game_over;
  logic [1:0] winner;

  hit_health_ctrl #(
    .MAX_HEALTH    (100),
    .DAMAGE        (15),
    .HIT_RANGE     (40),
    .INVULN_FRAMES (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .start      (start),
    .HP_X_Pos   (HP_X_Pos),
    .NPC_X_Pos  (NPC_X_Pos),
    .HP_X       (HP_X),
    .NPC_X      (NPC_X),
    .is_HPBeat  (is_HPBeat),
    .is_NPCBeat (is_NPCBeat),
    .HP_health  (HP_health),
    .NPC_health (NPC_health),
    .HP_hit     (HP_hit),
    .NPC_hit    (NPC_hit),
    .HP_invuln  (HP_invuln),
    .NPC_invuln (NPC_invuln),
    .HP_flash   (HP_flash),
    .NPC_flash  (NPC_flash),
    .game_over  (game_over),
    .winner     (winner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    int    hp;
    int    npc;
    int    hph;
    int    npch;
    int    hpi;
    int    npci;
    int    go;
    int    win;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  int   hp_hit_seen = 0;
  int   npc_hit_seen = 0;

  always @(negedge Clk) begin
    if (HP_hit)  hp_hit_seen  = hp_hit_seen + 1;
    if (NPC_hit) npc_hit_seen = npc_hit_seen + 1;
  end

  task automatic cmp(input string nm, input int act, input int exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: pops one expectation per sample event; hit pulses are counted since the previous sample.
  initial begin
    int   hp_last;
    int   npc_last;
    exp_t e;
    hp_last  = 0;
    npc_last = 0;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      end else begin
        e = sb_q.pop_front();
        cmp({e.name, ".HP_health"},  int'(HP_health),  e.hp);
        cmp({e.name, ".NPC_health"}, int'(NPC_health), e.npc);
        cmp({e.name, ".HP_hit_cycles"},  hp_hit_seen - hp_last,   e.hph);
        cmp({e.name, ".NPC_hit_cycles"}, npc_hit_seen - npc_last, e.npch);
        cmp({e.name, ".HP_invuln"},  int'(HP_invuln),  e.hpi);
        cmp({e.name, ".NPC_invuln"}, int'(NPC_invuln), e.npci);
        cmp({e.name, ".game_over"},  int'(game_over),  e.go);
        cmp({e.name, ".winner"},     int'(winner),     e.win);
`ifndef HIT_FLASH_EN
        cmp({e.name, ".HP_flash"},   int'(HP_flash),   0);
        cmp({e.name, ".NPC_flash"},  int'(NPC_flash),  0);
`endif
      end
      hp_last  = hp_hit_seen;
      npc_last = npc_hit_seen;
    end
  end

  task automatic do_frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_frame();
  endtask

  task automatic expect_now(input string nm, input int hp, input int npc, input int hph,
                            input int npch, input int hpi, input int npci, input int go,
                            input int win);
    exp_t e;
    e.name = nm; e.hp = hp; e.npc = npc; e.hph = hph; e.npch = npch;
    e.hpi = hpi; e.npci = npci; e.go = go; e.win = win;
    sb_q.push_back(e);
    ->sample_ev;
    @(negedge Clk);
  endtask

  task automatic chk_tick(input string nm, input int hp, input int npc, input int hph,
                          input int npch, input int hpi, input int npci, input int go,
                          input int win);
    do_frame();
    expect_now(nm, hp, npc, hph, npch, hpi, npci, go, win);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; start = 1'b0;
    HP_X_Pos = 10'd100; NPC_X_Pos = 10'd330; HP_X = 10'd300; NPC_X = 10'd600;
    is_HPBeat = 1'b0; is_NPCBeat = 1'b0;
    repeat (3) @(negedge Clk);
    expect_now("reset", 100, 100, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    start = 1'b1;
    repeat (3) @(negedge Clk);

    // Overlap held: one hit, 16 blocked ticks, then the next hit lands.
    is_HPBeat = 1'b1;
    chk_tick("first_hit", 100, 85, 0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 16; i++)
      chk_tick($sformatf("invuln_%0d", i), 100, 85, 0, 0, 0, (i < 16) ? 1 : 0, 0, 0);
    chk_tick("second_hit", 100, 70, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) chk_tick($sformatf("hold_%0d", i), 100, 70, 0, 0, 0, 1, 0, 0);
    is_HPBeat = 1'b0;

    // Range edge for the HP fighter: 41 misses, 40 (on the other side) hits.
    is_NPCBeat = 1'b1; NPC_X = 10'd141;
    chk_tick("range_41_miss", 100, 70, 0, 0, 0, 1, 0, 0);
    NPC_X = 10'd60;
    chk_tick("range_40_hit", 85, 70, 1, 0, 1, 1, 0, 0);
    is_NPCBeat = 1'b0;
    idle_ticks(16);

    // Walk NPC down; 10 -> 0 saturates and ends the round.
    for (int i = 0; i < 4; i++) begin
      is_HPBeat = 1'b1;
      chk_tick($sformatf("npc_down_%0d", i), 85, 55 - 15 * i, 0, 1, 0, 1, 0, 0);
      is_HPBeat = 1'b0;
      idle_ticks(16);
    end
    is_HPBeat = 1'b1;
    chk_tick("ko_npc", 85, 0, 0, 1, 0, 1, 1, 1);
    is_NPCBeat = 1'b1;
    chk_tick("ko_frozen_a", 85, 0, 0, 0, 0, 1, 1, 1);
    chk_tick("ko_frozen_b", 85, 0, 0, 0, 0, 1, 1, 1);
    repeat (5) @(negedge Clk);
    expect_now("ko_start_held", 85, 0, 0, 0, 0, 1, 1, 1);

    start = 1'b0;
    repeat (2) @(negedge Clk);
    start = 1'b1;
    repeat (3) @(negedge Clk);
    expect_now("restart", 100, 100, 0, 0, 0, 0, 0, 0);

    // Simultaneous hits every 17 ticks until both reach 0 together.
    for (int k = 1; k <= 6; k++) begin
      is_HPBeat = 1'b1; is_NPCBeat = 1'b1;
      chk_tick($sformatf("both_%0d", k), 100 - 15 * k, 100 - 15 * k, 1, 1, 1, 1, 0, 0);
      is_HPBeat = 1'b0; is_NPCBeat = 1'b0;
      idle_ticks(16);
    end
    is_HPBeat = 1'b1; is_NPCBeat = 1'b1;
    chk_tick("draw", 0, 0, 1, 1, 1, 1, 1, 3);
    is_HPBeat = 1'b0; is_NPCBeat = 1'b0;

    start = 1'b0;
    repeat (2) @(negedge Clk);
    start = 1'b1;
    repeat (3) @(negedge Clk);
    expect_now("restart_after_draw", 100, 100, 0, 0, 0, 0, 0, 0);
    is_HPBeat = 1'b1;
    chk_tick("round3_hit", 100, 85, 0, 1, 0, 1, 0, 0);

    @(negedge Clk);
    Reset = 1'b0;
    #1;
    expect_now("reset_mid_round", 100, 100, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    is_HPBeat = 1'b1; is_NPCBeat = 1'b1;
    chk_tick("idle_ignores_hits", 100, 100, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    repeat (3) @(negedge Clk);
    chk_tick("fight_after_reset", 85, 85, 1, 1, 1, 1, 0, 0);

    repeat (4) @(negedge Clk);
    cmp("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
